// File: rtl/ysyx_220053_trap_seq.sv
// Trap sequencer: turns retiring ecall/ebreak/illegal/mret events into
// a CSR trap write plus a PC redirect handshake with fetch.
module ysyx_220053_trap_seq #(
  parameter int XLEN        = 64,
  parameter int CNT_W       = 32,
  parameter int ECALL_CAUSE = 11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ev_valid,
  output logic            ev_ready,
  input  logic            ev_ecall,
  input  logic            ev_ebreak,
  input  logic            ev_illegal,
  input  logic            ev_mret,
  input  logic [XLEN-1:0] ev_pc,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  output logic            csr_ecall,
  output logic [XLEN-1:0] csr_epc,
  output logic [XLEN-1:0] csr_cause,
  output logic            csr_op_ovr,
  output logic            redir_valid,
  output logic [XLEN-1:0] redir_pc,
  input  logic            redir_ready,
  output logic            flush,
  output logic [CNT_W-1:0] trap_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRAP  = 2'd1,
    REDIR = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   epc_q, epc_d;
  logic [XLEN-1:0]   cause_q, cause_d;
  logic [XLEN-1:0]   target_q, target_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Vector mode bits of mtvec and mepc alignment bits are dropped.
  logic unused_lsbs;
  assign unused_lsbs = ^{mtvec_i[1:0], mepc_i[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      epc_q    <= '0;
      cause_q  <= '0;
      target_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      epc_q    <= epc_d;
      cause_q  <= cause_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    epc_d    = epc_q;
    cause_d  = cause_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (ev_valid) begin
          priority case (1'b1)
            ev_illegal: begin
              epc_d   = ev_pc;
              cause_d = XLEN'(2);
              state_d = TRAP;
            end
            ev_ebreak: begin
              epc_d   = ev_pc;
              cause_d = XLEN'(3);
              state_d = TRAP;
            end
            ev_ecall: begin
              epc_d   = ev_pc;
              cause_d = XLEN'(ECALL_CAUSE);
              state_d = TRAP;
            end
            ev_mret: begin
              target_d = {mepc_i[XLEN-1:2], 2'b00};
              state_d  = REDIR;
            end
            default: ;
          endcase
        end
      end
      TRAP: begin
        target_d = {mtvec_i[XLEN-1:2], 2'b00};
        cnt_d    = cnt_q + CNT_W'(1);
        state_d  = REDIR;
      end
      REDIR: begin
        if (redir_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ev_ready    = (state_q == IDLE);
    flush       = (state_q != IDLE);
    csr_ecall   = (state_q == TRAP);
    csr_op_ovr  = (state_q == TRAP);
    csr_epc     = (state_q == TRAP) ? epc_q : '0;
    csr_cause   = (state_q == TRAP) ? cause_q : '0;
    redir_valid = (state_q == REDIR);
    redir_pc    = (state_q == REDIR) ? target_q : '0;
    trap_cnt    = cnt_q;
  end

endmodule

// File: tb/tb_ysyx_220053_trap_seq.sv
// Bench for the trap sequencer: directed scenarios plus random events
// checked against an event-level model of the trap/redirect rules.
module tb_ysyx_220053_trap_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        ev_valid, ev_ecall, ev_ebreak, ev_illegal, ev_mret;
  logic [63:0] ev_pc, mtvec_i, mepc_i;
  logic        redir_ready;

  logic        ev_ready, csr_ecall, csr_op_ovr, redir_valid, flush;
  logic [63:0] csr_epc, csr_cause, redir_pc;
  logic [31:0] trap_cnt;

  logic        ev_ready4, csr_ecall4, csr_op_ovr4, redir_valid4, flush4;
  logic [63:0] csr_epc4, csr_cause4, redir_pc4;
  logic [3:0]  trap_cnt4;

  int vectors = 0;
  int errs    = 0;
  longint exp_cnt = 0;

  always #5 clk = ~clk;

  ysyx_220053_trap_seq dut (
    .clk(clk), .rst(rst),
    .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_ecall(ev_ecall), .ev_ebreak(ev_ebreak),
    .ev_illegal(ev_illegal), .ev_mret(ev_mret),
    .ev_pc(ev_pc), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
    .csr_ecall(csr_ecall), .csr_epc(csr_epc),
    .csr_cause(csr_cause), .csr_op_ovr(csr_op_ovr),
    .redir_valid(redir_valid), .redir_pc(redir_pc),
    .redir_ready(redir_ready), .flush(flush),
    .trap_cnt(trap_cnt)
  );

  ysyx_220053_trap_seq #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .ev_valid(ev_valid), .ev_ready(ev_ready4),
    .ev_ecall(ev_ecall), .ev_ebreak(ev_ebreak),
    .ev_illegal(ev_illegal), .ev_mret(ev_mret),
    .ev_pc(ev_pc), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
    .csr_ecall(csr_ecall4), .csr_epc(csr_epc4),
    .csr_cause(csr_cause4), .csr_op_ovr(csr_op_ovr4),
    .redir_valid(redir_valid4), .redir_pc(redir_pc4),
    .redir_ready(redir_ready), .flush(flush4),
    .trap_cnt(trap_cnt4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_cnt"}, 64'(trap_cnt), 64'(exp_cnt % 64'h1_0000_0000));
    chk({tag, "_cnt4"}, 64'(trap_cnt4), 64'(exp_cnt % 16));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ev_ready"}, 64'(ev_ready), 64'd1);
    chk({tag, "_flush"}, 64'(flush), 64'd0);
    chk({tag, "_redir_valid"}, 64'(redir_valid), 64'd0);
    chk({tag, "_csr_ecall"}, 64'(csr_ecall), 64'd0);
    chk_cnt(tag);
  endtask

  task automatic clear_ev();
    ev_valid   = 1'b0;
    ev_ecall   = 1'b0;
    ev_ebreak  = 1'b0;
    ev_illegal = 1'b0;
    ev_mret    = 1'b0;
  endtask

  // f = {illegal, ebreak, ecall, mret}; called in IDLE, #1 after an edge
  task automatic do_event(input string tag, input logic vld,
                          input logic [3:0] f, input logic [63:0] pc,
                          input logic [63:0] tv, input logic [63:0] mp,
                          input int stall, input bit rst_in_redir);
    logic        is_trap;
    logic [63:0] cause, tgt;
    ev_valid = vld;
    {ev_illegal, ev_ebreak, ev_ecall, ev_mret} = f;
    ev_pc   = pc;
    mtvec_i = tv;
    mepc_i  = mp;
    chk({tag, "_accept_ready"}, 64'(ev_ready), 64'd1);
    is_trap = f[3] | f[2] | f[1];
    cause = f[3] ? 64'd2 : f[2] ? 64'd3 : 64'd11;
    if (!vld || f == 4'b0000) begin
      step();
      clear_ev();
      chk_idle({tag, "_ignored"});
      return;
    end
    step();
    // Younger events and early ready must be ignored from here on
    ev_valid   = 1'b1;
    ev_illegal = 1'b1;
    ev_pc      = {$urandom, $urandom};
    mepc_i     = {$urandom, $urandom};
    if (is_trap) begin
      redir_ready = 1'($urandom);
      chk({tag, "_csr_ecall"}, 64'(csr_ecall), 64'd1);
      chk({tag, "_csr_op_ovr"}, 64'(csr_op_ovr), 64'd1);
      chk({tag, "_csr_epc"}, csr_epc, pc);
      chk({tag, "_csr_cause"}, csr_cause, cause);
      chk({tag, "_trap_flush"}, 64'(flush), 64'd1);
      chk({tag, "_trap_ev_ready"}, 64'(ev_ready), 64'd0);
      chk({tag, "_trap_redir_valid"}, 64'(redir_valid), 64'd0);
      exp_cnt++;
      tgt = tv & ~64'd3;
      step();
      mtvec_i = {$urandom, $urandom};
    end else begin
      tgt = mp & ~64'd3;
    end
    redir_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      chk({tag, "_stall_valid"}, 64'(redir_valid), 64'd1);
      chk({tag, "_stall_pc"}, redir_pc, tgt);
      chk({tag, "_stall_flush"}, 64'(flush), 64'd1);
      chk({tag, "_stall_ev_ready"}, 64'(ev_ready), 64'd0);
      step();
    end
    chk({tag, "_redir_valid"}, 64'(redir_valid), 64'd1);
    chk({tag, "_redir_pc"}, redir_pc, tgt);
    chk({tag, "_redir_csr_ecall"}, 64'(csr_ecall), 64'd0);
    chk_cnt({tag, "_redir"});
    if (rst_in_redir) begin
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_cnt = 0;
    end else begin
      redir_ready = 1'b1;
      step();
    end
    redir_ready = 1'b0;
    clear_ev();
    chk_idle({tag, "_done"});
  endtask

  initial begin
    rst = 1'b1;
    redir_ready = 1'b0;
    clear_ev();
    ev_pc = '0;
    mtvec_i = '0;
    mepc_i = '0;
    step();
    step();
    rst = 1'b0;
    chk_idle("reset");
    chk("reset_csr_epc", csr_epc, 64'd0);
    chk("reset_csr_cause", csr_cause, 64'd0);
    chk("reset_redir_pc", redir_pc, 64'd0);
    chk("reset_op_ovr", 64'(csr_op_ovr), 64'd0);

    do_event("ecall", 1'b1, 4'b0010, 64'h8000_0010, 64'h8000_0100,
             64'h0, 0, 1'b0);
    do_event("mret", 1'b1, 4'b0001, 64'h0, 64'h0, 64'h8000_0014,
             0, 1'b0);
    do_event("ecall_illegal", 1'b1, 4'b1010, 64'h8000_0020,
             64'h8000_0200, 64'h0, 0, 1'b0);
    do_event("stall5", 1'b1, 4'b0100, 64'h8000_0030, 64'h8000_0300,
             64'h0, 5, 1'b0);
    do_event("novalid", 1'b0, 4'b0010, 64'h1, 64'h2, 64'h3, 0, 1'b0);
    do_event("noflag", 1'b1, 4'b0000, 64'h1, 64'h2, 64'h3, 0, 1'b0);
    do_event("rst_redir", 1'b1, 4'b0010, 64'h8000_0040,
             64'h8000_0400, 64'h0, 1, 1'b1);

    for (int i = 0; i < 16; i++)
      do_event("wrap", 1'b1, 4'b0010, 64'h8000_1000 + 64'(i * 4),
               64'hFFFF_0000_0000_0103, 64'h0, 0, 1'b0);

    for (int i = 0; i < 40; i++)
      do_event("rand", 1'($urandom_range(0, 7) != 0),
               4'($urandom), {$urandom, $urandom},
               {$urandom, $urandom}, {$urandom, $urandom},
               int'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
